execute_md: RTL and testbench
=============================

EXECUTE_MD -- requirements
Module: execute_md

Interface
REQ-001 Parameter DATA_WIDTH, default 32: operand/result width.
REQ-002 Parameter MUL_STAGES, default 2: multiplier pipeline depth, range 1..4.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ValidE_i  in  1  an instruction is present in EX this cycle.
REQ-006 FlushE_i  in  1  kill the EX instruction, including any in-flight mul/div.
REQ-007 ALUCtrl_i  in  4  ALU operation, existing team encoding.
REQ-008 MDEn_i  in  1  the instruction is an M-extension op.
REQ-009 MDOp_i  in  3  funct3 encoding: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
REQ-010 ALUSrc_i  in  1  selects SrcB: 1 = ImmExtE_i, 0 = forwarded RD2.
REQ-011 JumpCtrl_i  in  1  selects PCTargetE_o: 1 = JALR target, 0 = PCE_i + ImmExtE_i.
REQ-012 ForwardAE_i  in  2  SrcA source: 00 = RD1E_i, 01 = ResultW_i, 10 = ALUResultM_i.
REQ-013 ForwardBE_i  in  2  RD2 source, same encoding as ForwardAE_i.
REQ-014 RD1E_i, RD2E_i  in  DATA_WIDTH each  register-file operands.
REQ-015 PCE_i, ImmExtE_i  in  DATA_WIDTH each  PC and extended immediate.
REQ-016 ResultW_i, ALUResultM_i  in  DATA_WIDTH each  forwarding sources.
REQ-017 StallE_o  out  1  EX is busy; upstream shall hold IF/ID/EX.
REQ-018 ValidE_o  out  1  ResultE_o is valid for the EX/MEM register this cycle.
REQ-019 ResultE_o  out  DATA_WIDTH  ALU or mul/div result.
REQ-020 WriteDataE_o  out  DATA_WIDTH  forwarded RD2, used as store data.
REQ-021 PCTargetE_o  out  DATA_WIDTH  branch/jump target.
REQ-022 Zero_o  out  1  ALU result equals zero.

Function
REQ-023 With MDEn_i=0, the path shall be combinational: ValidE_o=ValidE_i and StallE_o=0.
REQ-024 The JALR target shall be (SrcA + ImmExtE_i) with bit 0 cleared; WriteDataE_o shall be the forwarded RD2 regardless of ALUSrc_i.
REQ-025 FSM states: IDLE, MUL, DIV, DONE; the FSM shall reset to IDLE.
REQ-026 IDLE: on ValidE_i & MDEn_i & ~FlushE_i, latch operands and op, assert StallE_o in the same cycle, then go to MUL (MDOp_i[2]=0) or DIV (MDOp_i[2]=1).
REQ-027 MUL: the full 2*DATA_WIDTH product shall be available after MUL_STAGES cycles, signed/unsigned per op; MUL returns the low half, all others return the high half.
REQ-028 DIV: radix-2 restoring divider on magnitudes, one quotient bit per cycle, DATA_WIDTH cycles, then sign fix-up.
REQ-029 Divide by zero shall complete in 1 cycle: quotient all-ones, remainder = dividend.
REQ-030 Signed overflow (most negative / -1) shall complete in 1 cycle: quotient = dividend, remainder 0.
REQ-031 DONE: drive ResultE_o, ValidE_o=1, StallE_o=0 for exactly one cycle, then go to IDLE.
REQ-032 Operands shall be latched at start, so forwarding-input changes during a stall shall not affect the result.
REQ-033 FlushE_i in any state shall return the FSM to IDLE next edge, with no ValidE_o pulse and StallE_o=0 in the flush cycle.
REQ-034 ValidE_o shall be 0 in MUL and DIV.

Reset
REQ-035 While rst is high: FSM=IDLE, StallE_o=0, ValidE_o=0, and all internal registers cleared; combinational outputs follow inputs.
REQ-036 Reset asserted mid-operation shall discard the operation; the first cycle after release is IDLE.

Structure
REQ-037 The ALUCtrl, MDOp and Forward encodings and the FSM state enum shall live in the shared riscv package.
REQ-038 The iterative divider shall be sub-module md_divider (start/busy/done handshake); the existing ALU shall be instantiated unchanged.

Verification
REQ-039 ADD via ALU, ForwardAE_i=10, ALUResultM_i=5, RD2E_i=7 -> ResultE_o=12, ValidE_o=1 in the same cycle, StallE_o=0.
REQ-040 MULH, 0x80000000 x 0x80000000 -> after MUL_STAGES cycles ResultE_o=0x40000000, single ValidE_o pulse.
REQ-041 DIV -7/2 -> ResultE_o=0xFFFFFFFD after 32+1 cycles; REM -7/2 -> 0xFFFFFFFF.
REQ-042 DIVU 5/0 -> 0xFFFFFFFF; DIV 0x80000000 / -1 -> 0x80000000, each with a 1-cycle latency.
REQ-043 FlushE_i in DIV cycle 10 -> no ValidE_o, StallE_o=0, and the next ADD issues correctly.
REQ-044 JALR with SrcA=0x1001 and Imm=4 -> PCTargetE_o=0x1004.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RISC-V core definitions: ALU control codes, M-extension funct3
// codes, forwarding-mux selects and the EX mul/div sequencer states.
package riscv_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SLL  = 4'b0111,
    ALU_SRL  = 4'b1000,
    ALU_SRA  = 4'b1001,
    ALU_LUI  = 4'b1010
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    MD_MUL    = 3'b000,
    MD_MULH   = 3'b001,
    MD_MULHSU = 3'b010,
    MD_MULHU  = 3'b011,
    MD_DIV    = 3'b100,
    MD_DIVU   = 3'b101,
    MD_REM    = 3'b110,
    MD_REMU   = 3'b111
  } md_op_e;

  typedef enum logic [1:0] {
    FWD_RD  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_sel_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_DONE
  } md_state_e;

  // funct3 decode helpers for the M extension
  function automatic logic md_is_div(input logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic md_div_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic md_want_rem(input logic [2:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu.sv
// Integer ALU.
// Ports: SrcA_i/SrcB_i operands, ALUCtrl_i operation (riscv_pkg::alu_ctrl_e),
//        ALUResult_o result, Zero_o result equals zero.
module alu
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] SrcA_i,
  input  logic [DATA_WIDTH-1:0] SrcB_i,
  input  logic [3:0]            ALUCtrl_i,
  output logic [DATA_WIDTH-1:0] ALUResult_o,
  output logic                  Zero_o
);

  localparam int unsigned SHW = $clog2(DATA_WIDTH);

  logic [SHW-1:0] shamt;
  assign shamt = SrcB_i[SHW-1:0];

  always_comb begin
    ALUResult_o = '0;
    case (ALUCtrl_i)
      ALU_ADD:  ALUResult_o = SrcA_i + SrcB_i;
      ALU_SUB:  ALUResult_o = SrcA_i - SrcB_i;
      ALU_AND:  ALUResult_o = SrcA_i & SrcB_i;
      ALU_OR:   ALUResult_o = SrcA_i | SrcB_i;
      ALU_XOR:  ALUResult_o = SrcA_i ^ SrcB_i;
      ALU_SLT:  ALUResult_o = {{(DATA_WIDTH-1){1'b0}}, ($signed(SrcA_i) < $signed(SrcB_i))};
      ALU_SLTU: ALUResult_o = {{(DATA_WIDTH-1){1'b0}}, (SrcA_i < SrcB_i)};
      ALU_SLL:  ALUResult_o = SrcA_i << shamt;
      ALU_SRL:  ALUResult_o = SrcA_i >> shamt;
      ALU_SRA:  ALUResult_o = $unsigned($signed(SrcA_i) >>> shamt);
      ALU_LUI:  ALUResult_o = SrcB_i;
      default:  ALUResult_o = '0;
    endcase
  end

  assign Zero_o = (ALUResult_o == '0);

endmodule

// File: rtl/md_divider.sv
// Iterative radix-2 restoring divider working on operand magnitudes, one
// quotient bit per cycle, with sign fix-up applied on the outputs.
// Divide-by-zero and signed overflow finish after a single busy cycle.
// Ports: clk, rst (async, active-high), start_i (load operands), flush_i
//        (abort), signed_i (DIV/REM vs DIVU/REMU), dividend_i, divisor_i,
//        busy_o (operation in progress), done_o (last busy cycle),
//        quotient_o/remainder_o (valid from the cycle after done_o).
module md_divider #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start_i,
  input  logic                  flush_i,
  input  logic                  signed_i,
  input  logic [DATA_WIDTH-1:0] dividend_i,
  input  logic [DATA_WIDTH-1:0] divisor_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [DATA_WIDTH-1:0] quotient_o,
  output logic [DATA_WIDTH-1:0] remainder_o
);

  localparam int unsigned W  = DATA_WIDTH;
  localparam int unsigned CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

  logic          busy_q, special_q, div_zero_q, neg_quo_q, neg_rem_q;
  logic [CW-1:0] cnt_q;
  logic [W-1:0]  dividend_q, dvs_q, quo_q, rem_q;

  logic          dividend_neg, divisor_neg, div_zero, overflow;
  logic [W-1:0]  mag_a, mag_b;
  logic [W:0]    trial;

  assign dividend_neg = signed_i & dividend_i[W-1];
  assign divisor_neg  = signed_i & divisor_i[W-1];
  assign mag_a        = dividend_neg ? -dividend_i : dividend_i;
  assign mag_b        = divisor_neg  ? -divisor_i  : divisor_i;
  assign div_zero     = (divisor_i == '0);
  assign overflow     = signed_i & (dividend_i == {1'b1, {(W-1){1'b0}}}) & (divisor_i == '1);

  // Shifted partial remainder minus divisor; a clear top bit means it fits.
  assign trial = {rem_q, quo_q[W-1]} - {1'b0, dvs_q};

  assign busy_o = busy_q;
  assign done_o = busy_q & (special_q | (cnt_q == LAST));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q     <= 1'b0;
      special_q  <= 1'b0;
      div_zero_q <= 1'b0;
      neg_quo_q  <= 1'b0;
      neg_rem_q  <= 1'b0;
      cnt_q      <= '0;
      dividend_q <= '0;
      dvs_q      <= '0;
      quo_q      <= '0;
      rem_q      <= '0;
    end else if (flush_i) begin
      busy_q <= 1'b0;
    end else if (start_i) begin
      busy_q     <= 1'b1;
      special_q  <= div_zero | overflow;
      div_zero_q <= div_zero;
      neg_quo_q  <= dividend_neg ^ divisor_neg;
      neg_rem_q  <= dividend_neg;
      cnt_q      <= '0;
      dividend_q <= dividend_i;
      dvs_q      <= mag_b;
      quo_q      <= mag_a;
      rem_q      <= '0;
    end else if (busy_q) begin
      if (done_o) begin
        busy_q <= 1'b0;
      end
      if (!special_q) begin
        cnt_q <= cnt_q + 1'b1;
        if (!trial[W]) begin
          rem_q <= trial[W-1:0];
          quo_q <= {quo_q[W-2:0], 1'b1};
        end else begin
          rem_q <= {rem_q[W-2:0], quo_q[W-1]};
          quo_q <= {quo_q[W-2:0], 1'b0};
        end
      end
    end
  end

  always_comb begin
    quotient_o  = neg_quo_q ? -quo_q : quo_q;
    remainder_o = neg_rem_q ? -rem_q : rem_q;
    if (div_zero_q) begin
      quotient_o  = '1;
      remainder_o = dividend_q;
    end else if (special_q) begin
      quotient_o  = dividend_q;
      remainder_o = '0;
    end
  end

endmodule

// File: rtl/execute_md.sv
// Execute stage with forwarding muxes, ALU, branch/jump target adder and a
// multi-cycle M-extension unit (pipelined multiplier, iterative divider).
// ALU instructions complete combinationally; mul/div stall upstream until a
// single-cycle DONE pulse presents the result.
// Ports: clk, rst (async, active-high); ValidE_i, FlushE_i, ALUCtrl_i,
//        MDEn_i, MDOp_i, ALUSrc_i, JumpCtrl_i, ForwardAE_i, ForwardBE_i,
//        RD1E_i, RD2E_i, PCE_i, ImmExtE_i, ResultW_i, ALUResultM_i in;
//        StallE_o, ValidE_o, ResultE_o, WriteDataE_o, PCTargetE_o, Zero_o out.
module execute_md
  import riscv_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ValidE_i,
  input  logic                  FlushE_i,
  input  logic [3:0]            ALUCtrl_i,
  input  logic                  MDEn_i,
  input  logic [2:0]            MDOp_i,
  input  logic                  ALUSrc_i,
  input  logic                  JumpCtrl_i,
  input  logic [1:0]            ForwardAE_i,
  input  logic [1:0]            ForwardBE_i,
  input  logic [DATA_WIDTH-1:0] RD1E_i,
  input  logic [DATA_WIDTH-1:0] RD2E_i,
  input  logic [DATA_WIDTH-1:0] PCE_i,
  input  logic [DATA_WIDTH-1:0] ImmExtE_i,
  input  logic [DATA_WIDTH-1:0] ResultW_i,
  input  logic [DATA_WIDTH-1:0] ALUResultM_i,
  output logic                  StallE_o,
  output logic                  ValidE_o,
  output logic [DATA_WIDTH-1:0] ResultE_o,
  output logic [DATA_WIDTH-1:0] WriteDataE_o,
  output logic [DATA_WIDTH-1:0] PCTargetE_o,
  output logic                  Zero_o
);

  localparam int unsigned W = DATA_WIDTH;
  localparam logic [1:0] MUL_LAST = 2'(MUL_STAGES - 1);

  md_state_e    state_q, state_d;
  logic [W-1:0] src_a, rd2_fwd, src_b, alu_result, jalr_sum;
  logic         stall, valid, md_start, div_start;
  logic [W-1:0] result;

  logic [2:0]   op_q;
  logic [W-1:0] a_q, b_q;
  logic [1:0]   mul_cnt_q;
  logic         a_signed, b_signed;
  logic [2*W-1:0] a_ext, b_ext, mul_prod;
  logic [2*W-1:0] mul_pipe_q [MUL_STAGES];
  logic [W-1:0] md_result;

  logic         div_busy, div_done;
  logic [W-1:0] div_quo, div_rem;

  always_comb begin
    case (ForwardAE_i)
      FWD_WB:  src_a = ResultW_i;
      FWD_MEM: src_a = ALUResultM_i;
      default: src_a = RD1E_i;
    endcase
    case (ForwardBE_i)
      FWD_WB:  rd2_fwd = ResultW_i;
      FWD_MEM: rd2_fwd = ALUResultM_i;
      default: rd2_fwd = RD2E_i;
    endcase
  end

  assign src_b        = ALUSrc_i ? ImmExtE_i : rd2_fwd;
  assign WriteDataE_o = rd2_fwd;
  assign jalr_sum     = src_a + ImmExtE_i;
  assign PCTargetE_o  = JumpCtrl_i ? {jalr_sum[W-1:1], 1'b0} : (PCE_i + ImmExtE_i);

  alu #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_alu (
    .SrcA_i     (src_a),
    .SrcB_i     (src_b),
    .ALUCtrl_i  (ALUCtrl_i),
    .ALUResult_o(alu_result),
    .Zero_o     (Zero_o)
  );

  assign md_start  = (state_q == S_IDLE) & ValidE_i & MDEn_i & ~FlushE_i;
  assign div_start = md_start & md_is_div(MDOp_i) & ~div_busy;

  md_divider #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_div (
    .clk        (clk),
    .rst        (rst),
    .start_i    (div_start),
    .flush_i    (FlushE_i),
    .signed_i   (md_div_signed(MDOp_i)),
    .dividend_i (src_a),
    .divisor_i  (rd2_fwd),
    .busy_o     (div_busy),
    .done_o     (div_done),
    .quotient_o (div_quo),
    .remainder_o(div_rem)
  );

  // Operands are sign- or zero-extended to 2W so an unsigned 2W-bit product
  // yields the correct low 2W bits for every signedness combination.
  assign a_signed = (op_q == MD_MULH) | (op_q == MD_MULHSU);
  assign b_signed = (op_q == MD_MULH);
  assign a_ext    = {{W{a_signed & a_q[W-1]}}, a_q};
  assign b_ext    = {{W{b_signed & b_q[W-1]}}, b_q};
  assign mul_prod = a_ext * b_ext;

  always_comb begin
    if (md_is_div(op_q)) begin
      md_result = md_want_rem(op_q) ? div_rem : div_quo;
    end else if (op_q == MD_MUL) begin
      md_result = mul_pipe_q[MUL_STAGES-1][W-1:0];
    end else begin
      md_result = mul_pipe_q[MUL_STAGES-1][2*W-1:W];
    end
  end

  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    valid   = 1'b0;
    result  = alu_result;
    case (state_q)
      S_IDLE: begin
        valid = ValidE_i & ~MDEn_i;
        if (md_start) begin
          stall   = 1'b1;
          state_d = md_is_div(MDOp_i) ? S_DIV : S_MUL;
        end
      end
      S_MUL: begin
        stall = 1'b1;
        if (mul_cnt_q == MUL_LAST) begin
          state_d = S_DONE;
        end
      end
      S_DIV: begin
        stall = 1'b1;
        if (div_done) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        valid   = 1'b1;
        result  = md_result;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (FlushE_i) begin
      state_d = S_IDLE;
      stall   = 1'b0;
      valid   = 1'b0;
    end
  end

  assign StallE_o  = stall & ~rst;
  assign ValidE_o  = valid & ~rst;
  assign ResultE_o = result;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      mul_cnt_q <= '0;
      for (int unsigned i = 0; i < MUL_STAGES; i++) begin
        mul_pipe_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      if (md_start) begin
        op_q      <= MDOp_i;
        a_q       <= src_a;
        b_q       <= rd2_fwd;
        mul_cnt_q <= '0;
      end else if (state_q == S_MUL) begin
        mul_cnt_q <= mul_cnt_q + 1'b1;
      end
      mul_pipe_q[0] <= mul_prod;
      for (int unsigned i = 1; i < MUL_STAGES; i++) begin
        mul_pipe_q[i] <= mul_pipe_q[i-1];
      end
    end
  end

endmodule

// File: tb/tb_execute_md.sv
module tb_execute_md;
  import riscv_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ValidE_i, FlushE_i, MDEn_i, ALUSrc_i, JumpCtrl_i;
  logic [3:0]  ALUCtrl_i;
  logic [2:0]  MDOp_i;
  logic [1:0]  ForwardAE_i, ForwardBE_i;
  logic [31:0] RD1E_i, RD2E_i, PCE_i, ImmExtE_i, ResultW_i, ALUResultM_i;
  logic        StallE_o, ValidE_o, Zero_o;
  logic [31:0] ResultE_o, WriteDataE_o, PCTargetE_o;

  int checks = 0;
  int errors = 0;

  execute_md #(
    .DATA_WIDTH(32),
    .MUL_STAGES(2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ValidE_i    (ValidE_i),
    .FlushE_i    (FlushE_i),
    .ALUCtrl_i   (ALUCtrl_i),
    .MDEn_i      (MDEn_i),
    .MDOp_i      (MDOp_i),
    .ALUSrc_i    (ALUSrc_i),
    .JumpCtrl_i  (JumpCtrl_i),
    .ForwardAE_i (ForwardAE_i),
    .ForwardBE_i (ForwardBE_i),
    .RD1E_i      (RD1E_i),
    .RD2E_i      (RD2E_i),
    .PCE_i       (PCE_i),
    .ImmExtE_i   (ImmExtE_i),
    .ResultW_i   (ResultW_i),
    .ALUResultM_i(ALUResultM_i),
    .StallE_o    (StallE_o),
    .ValidE_o    (ValidE_o),
    .ResultE_o   (ResultE_o),
    .WriteDataE_o(WriteDataE_o),
    .PCTargetE_o (PCTargetE_o),
    .Zero_o      (Zero_o)
  );

  always #5 clk = ~clk;

  task automatic idle_inputs();
    ValidE_i = 0; FlushE_i = 0; MDEn_i = 0; ALUSrc_i = 0; JumpCtrl_i = 0;
    ALUCtrl_i = ALU_ADD; MDOp_i = MD_MUL; ForwardAE_i = 2'b00; ForwardBE_i = 2'b00;
    RD1E_i = 0; RD2E_i = 0; PCE_i = 0; ImmExtE_i = 0; ResultW_i = 0; ALUResultM_i = 0;
  endtask

  // Issue one M-extension op at cycle 0 and expect its ValidE_o pulse at cycle lat.
  task automatic run_md(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int lat);
    int seen;
    int bad_stall;
    @(negedge clk);
    ValidE_i = 1; MDEn_i = 1; MDOp_i = op; FlushE_i = 0; ALUSrc_i = 0;
    ForwardAE_i = 2'b00; ForwardBE_i = 2'b00; RD1E_i = a; RD2E_i = b;
    #1;
    checks++;
    if (StallE_o !== 1'b1 || ValidE_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: stall=%b valid=%b expected stall=1 valid=0", name, StallE_o, ValidE_o);
    end
    seen = -1;
    bad_stall = 0;
    for (int c = 1; c <= 40 && seen < 0; c++) begin
      @(negedge clk);
      // forwarding inputs change while stalled; result must use latched operands
      RD1E_i = $urandom; RD2E_i = $urandom; ResultW_i = $urandom;
      ForwardAE_i = 2'b01; ForwardBE_i = 2'b01;
      #1;
      if (ValidE_o === 1'b1) seen = c;
      else if (StallE_o !== 1'b1) bad_stall++;
    end
    checks++;
    if (seen != lat || bad_stall != 0) begin
      errors++;
      $display("FAIL %s_latency: valid at cycle %0d (stall drops %0d) expected cycle %0d", name, seen, bad_stall, lat);
    end
    checks++;
    if (ResultE_o !== exp || StallE_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_result: got %h stall=%b expected %h stall=0", name, ResultE_o, StallE_o, exp);
    end
    @(negedge clk);
    ValidE_i = 0; MDEn_i = 0; ForwardAE_i = 2'b00; ForwardBE_i = 2'b00;
    #1;
    checks++;
    if (ValidE_o !== 1'b0 || StallE_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_single_pulse: valid=%b stall=%b expected 0 0", name, ValidE_o, StallE_o);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    ValidE_i = 1; ALUCtrl_i = ALU_ADD; RD1E_i = 32'd1; RD2E_i = 32'd2;
    #1;
    checks++;
    if (ValidE_o !== 1'b0 || StallE_o !== 1'b0 || ResultE_o !== 32'd3) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b stall=%b res=%h expected 0 0 00000003", ValidE_o, StallE_o, ResultE_o);
    end
    MDEn_i = 1; MDOp_i = MD_DIV;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (StallE_o !== 1'b0 || ValidE_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_md_held: stall=%b valid=%b expected 0 0", StallE_o, ValidE_o);
    end
    @(negedge clk);
    idle_inputs();
    rst = 0;
    #1;
    checks++;
    if (StallE_o !== 1'b0 || ValidE_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: stall=%b valid=%b expected 0 0", StallE_o, ValidE_o);
    end
  endtask

  task automatic test_alu();
    @(negedge clk);
    idle_inputs();
    ValidE_i = 1; ALUCtrl_i = ALU_ADD; ForwardAE_i = 2'b10; ALUResultM_i = 32'd5;
    RD1E_i = 32'd99; RD2E_i = 32'd7;
    #1;
    checks++;
    if (ResultE_o !== 32'd12 || ValidE_o !== 1'b1 || StallE_o !== 1'b0) begin
      errors++;
      $display("FAIL alu_add_fwd_mem: res=%h valid=%b stall=%b expected 0000000c 1 0", ResultE_o, ValidE_o, StallE_o);
    end
    @(negedge clk);
    ALUCtrl_i = ALU_SUB; ForwardAE_i = 2'b01; ResultW_i = 32'd40; ForwardBE_i = 2'b00; RD2E_i = 32'd40;
    #1;
    checks++;
    if (ResultE_o !== 32'd0 || Zero_o !== 1'b1) begin
      errors++;
      $display("FAIL alu_sub_zero: res=%h zero=%b expected 00000000 1", ResultE_o, Zero_o);
    end
    @(negedge clk);
    ALUCtrl_i = ALU_ADD; ALUSrc_i = 1; ForwardAE_i = 2'b00; RD1E_i = 32'h100;
    ImmExtE_i = 32'h20; ForwardBE_i = 2'b01; ResultW_i = 32'h55;
    #1;
    checks++;
    if (ResultE_o !== 32'h120 || WriteDataE_o !== 32'h55 || Zero_o !== 1'b0) begin
      errors++;
      $display("FAIL alu_imm_store: res=%h wd=%h zero=%b expected 00000120 00000055 0", ResultE_o, WriteDataE_o, Zero_o);
    end
    @(negedge clk);
    idle_inputs();
  endtask

  task automatic test_pc_target();
    @(negedge clk);
    idle_inputs();
    JumpCtrl_i = 1; RD1E_i = 32'h1001; ImmExtE_i = 32'd4; PCE_i = 32'h8000;
    #1;
    checks++;
    if (PCTargetE_o !== 32'h1004) begin
      errors++;
      $display("FAIL jalr_target: got %h expected 00001004", PCTargetE_o);
    end
    JumpCtrl_i = 0; PCE_i = 32'h100; ImmExtE_i = 32'h21;
    #1;
    checks++;
    if (PCTargetE_o !== 32'h121) begin
      errors++;
      $display("FAIL branch_target: got %h expected 00000121", PCTargetE_o);
    end
    idle_inputs();
  endtask

  // MUL_STAGES=2: two MUL cycles, then DONE at cycle 3
  task automatic test_mul();
    run_md("mulh_min", MD_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 3);
    run_md("mul_low", MD_MUL, 32'd3, 32'hFFFF_FFFE, 32'hFFFF_FFFA, 3);
    run_md("mulhu", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 3);
    run_md("mulhsu", MD_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3);
  endtask

  // 32 DIV cycles then DONE at cycle 33; special cases take 1 DIV cycle (DONE at 2)
  task automatic test_div();
    run_md("div_neg", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_md("rem_neg", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_md("rem_negdivisor", MD_REM, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_md("divu", MD_DIVU, 32'd100, 32'd7, 32'd14, 33);
    run_md("remu", MD_REMU, 32'd100, 32'd7, 32'd2, 33);
    run_md("divu_zero", MD_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 2);
    run_md("remu_zero", MD_REMU, 32'd5, 32'd0, 32'd5, 2);
    run_md("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 2);
    run_md("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 2);
  endtask

  task automatic test_flush();
    int stray;
    @(negedge clk);
    idle_inputs();
    ValidE_i = 1; MDEn_i = 1; MDOp_i = MD_DIV; RD1E_i = 32'hFFFF_FFF9; RD2E_i = 32'd2;
    repeat (10) @(negedge clk);
    FlushE_i = 1;
    #1;
    checks++;
    if (StallE_o !== 1'b0 || ValidE_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_cycle: stall=%b valid=%b expected 0 0", StallE_o, ValidE_o);
    end
    @(negedge clk);
    FlushE_i = 0; MDEn_i = 0; ALUCtrl_i = ALU_ADD; RD1E_i = 32'd20; RD2E_i = 32'd22;
    #1;
    checks++;
    if (ResultE_o !== 32'd42 || ValidE_o !== 1'b1 || StallE_o !== 1'b0) begin
      errors++;
      $display("FAIL flush_next_add: res=%h valid=%b stall=%b expected 0000002a 1 0", ResultE_o, ValidE_o, StallE_o);
    end
    @(negedge clk);
    ValidE_i = 0;
    stray = 0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      #1;
      if (ValidE_o !== 1'b0 || StallE_o !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL flush_no_stray: %0d active cycles after flush expected 0", stray);
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_op();
    @(negedge clk);
    idle_inputs();
    ValidE_i = 1; MDEn_i = 1; MDOp_i = MD_DIVU; RD1E_i = 32'd1000; RD2E_i = 32'd3;
    repeat (5) @(negedge clk);
    rst = 1;
    #1;
    checks++;
    if (StallE_o !== 1'b0 || ValidE_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_op: stall=%b valid=%b expected 0 0", StallE_o, ValidE_o);
    end
    @(negedge clk);
    rst = 0;
    idle_inputs();
    #1;
    checks++;
    if (StallE_o !== 1'b0 || ValidE_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_release: stall=%b valid=%b expected 0 0", StallE_o, ValidE_o);
    end
    run_md("mul_after_reset", MD_MUL, 32'd6, 32'd7, 32'd42, 3);
  endtask

  initial begin
    test_reset();
    test_alu();
    test_pc_target();
    test_mul();
    test_div();
    test_flush();
    test_reset_mid_op();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
